fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered instructions (power of two, >=2).
REQ-002 Parameter ADDR_W, default 64, PC/address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_addr  output  ADDR_W  byte address of requested word.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_resp_valid  input  1  returned instruction word valid.
REQ-009 imem_resp_data  input  32  returned instruction word.
REQ-010 inst_valid  output  1  head entry available to CPU.
REQ-011 inst  output  32  head instruction.
REQ-012 inst_pc  output  ADDR_W  PC of head instruction.
REQ-013 inst_ready  input  1  CPU consumes head this cycle.
REQ-014 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-015 redirect_pc  input  ADDR_W  new fetch target.

Function
REQ-016 Handshakes SHALL complete on cycles where valid and ready are both high at the rising edge.
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DISCARD; at most one memory request outstanding.
REQ-018 IDLE->REQ when count < DEPTH; otherwise stay IDLE.
REQ-019 In REQ, imem_req_valid=1 and imem_req_addr=fetch_pc; addr and valid SHALL stay stable until accepted, except on redirect.
REQ-020 REQ->WAIT on acceptance; fetch_pc SHALL increment by 4 (wrap modulo 2^ADDR_W).
REQ-021 WAIT: on imem_resp_valid, push {fetch_pc-4, data}; next state REQ if post-push count < DEPTH, else IDLE.
REQ-022 Push SHALL appear at head no earlier than next cycle (resp at t -> inst_valid at t+1 when queue was empty).
REQ-023 Simultaneous push and pop SHALL be allowed at any count including full; count unchanged.
REQ-024 inst_valid SHALL equal (count != 0); inst/inst_pc SHALL be stable while inst_valid && !inst_ready.
REQ-025 Redirect SHALL flush the queue (count=0 next cycle) and load fetch_pc=redirect_pc; a same-cycle pop counts as completed.
REQ-026 Redirect in IDLE/REQ without same-cycle acceptance -> REQ with redirect_pc next cycle.
REQ-027 Redirect in REQ with same-cycle acceptance, or in WAIT without resp -> DISCARD.
REQ-028 Redirect in WAIT with same-cycle resp -> response dropped, state REQ.
REQ-029 DISCARD: drop next response, then -> REQ; redirect in DISCARD only updates fetch_pc.
REQ-030 Redirect SHALL take priority over push in the same cycle.

Reset
REQ-031 On reset: state IDLE, fetch_pc=0, count=0, read/write pointers 0, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
REQ-032 Reset mid-request SHALL abandon the request; no response arriving before the first post-reset request is pushed.

Structure
REQ-033 Package fetch_pkg SHALL hold ADDR_W/DEPTH defaults, INST_W=32, and the state enum type.
REQ-034 Storage SHALL be sub-module fetch_fifo (DEPTH entries of {pc, inst}, push/pop/flush, count); FSM and PC live in fetch_queue.

Verification
REQ-035 Reset, memory ready, 1-cycle resp, inst_ready=1 -> inst_pc sequence 0,4,8,12, inst matches memory.
REQ-036 inst_ready=0 for 10 cycles -> count saturates at 4, imem_req_valid low, no entry lost; release -> PCs 0..12 in order.
REQ-037 Redirect to 0x100 while WAIT -> stale response dropped, next inst_pc=0x100.
REQ-038 Full queue, pop and resp same cycle -> count stays 4, order preserved.
REQ-039 imem_req_ready low 5 cycles -> imem_req_addr stable; redirect mid-stall -> addr changes to redirect_pc.
REQ-040 Reset asserted in WAIT -> all outputs zero immediately; fetch restarts at PC 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
//   ADDR_W_DEFAULT / DEPTH_DEFAULT : default PC width and queue depth
//   INST_W                         : instruction word width
//   fetch_state_e                  : fetch controller states
package fetch_pkg;

  localparam int ADDR_W_DEFAULT = 64;
  localparam int DEPTH_DEFAULT  = 4;
  localparam int INST_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // queue full, no request in flight
    ST_REQ     = 2'd1,  // presenting a request to instruction memory
    ST_WAIT    = 2'd2,  // request accepted, waiting for its response
    ST_DISCARD = 2'd3   // request accepted but made stale by a redirect
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue storage: DEPTH entries of {pc, inst}.
//   clk, reset            : clock, asynchronous active-high reset
//   push, push_pc/inst    : write an entry (accepted when not full, or
//                           when a pop happens in the same cycle)
//   pop                   : drop the head entry (ignored when empty)
//   flush                 : empty the queue, wins over push and pop
//   head_valid/pc/inst    : head entry; pc/inst read as zero when empty
//   count                 : number of valid entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_pc,
  input  logic [INST_W-1:0]          push_inst,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       head_valid,
  output logic [ADDR_W-1:0]          head_pc,
  output logic [INST_W-1:0]          head_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             pop_eff;
  logic             push_eff;

  assign pop_eff  = pop && (count_reg != '0);
  // A full queue can still take a push if the head leaves in the same cycle.
  assign push_eff = push && ((count_reg != FULL_COUNT) || pop_eff);

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_eff) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop_eff)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (push_eff && !pop_eff)      count_next = count_reg + CNT_W'(1);
      else if (pop_eff && !push_eff) count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push_eff && !flush) begin
      pc_mem[wr_ptr_reg]   <= push_pc;
      inst_mem[wr_ptr_reg] <= push_inst;
    end
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != '0);
  assign head_pc    = head_valid ? pc_mem[rd_ptr_reg]   : '0;
  assign head_inst  = head_valid ? inst_mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues one memory request at a time, buffers
// returned words with their PCs and hands them to the CPU in order.
// A redirect flushes the queue and restarts fetching at redirect_pc; a
// response belonging to a request issued before the redirect is dropped.
//   clk, reset                         : clock, asynchronous active-high reset
//   imem_req_valid/addr/ready          : request channel to instruction memory
//   imem_resp_valid/data               : response channel from memory
//   inst_valid/inst/inst_pc/inst_ready : head of queue towards the CPU
//   redirect_valid/redirect_pc         : taken branch/jump, new fetch target
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  fetch_state_e      state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    post_push_count;
  logic              push;
  logic              pop;

  assign pop = inst_valid && inst_ready;

  // Occupancy after this cycle's push, accounting for a simultaneous pop.
  assign post_push_count = {1'b0, count} + (CNT_W+1)'(1)
                         - {{CNT_W{1'b0}}, pop};

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    push          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (redirect_valid || (count < FULL_COUNT)) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid) begin
          // An accepted request is in flight; its response is now stale.
          state_next = imem_req_ready ? ST_DISCARD : ST_REQ;
        end else if (imem_req_ready) begin
          state_next    = ST_WAIT;
          fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          state_next = imem_resp_valid ? ST_REQ : ST_DISCARD;
        end else if (imem_resp_valid) begin
          push       = 1'b1;
          state_next = (post_push_count < {1'b0, FULL_COUNT}) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (imem_resp_valid) state_next = ST_REQ;
      end
      default: state_next = ST_IDLE;
    endcase
    if (redirect_valid) fetch_pc_next = redirect_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      fetch_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  assign imem_req_valid = (state_reg == ST_REQ);
  assign imem_req_addr  = fetch_pc_reg;

  // fetch_pc was advanced on acceptance, so the pending word sits 4 below it.
  fetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_pc    (fetch_pc_reg - ADDR_W'(4)),
    .push_inst  (imem_resp_data),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_valid (inst_valid),
    .head_pc    (inst_pc),
    .head_inst  (inst),
    .count      (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_resp_valid;
  logic [31:0]       imem_resp_data;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the sequence of words the CPU should see.
  typedef struct { logic [63:0] pc; logic [31:0] ins; } entry_t;
  entry_t      model_q[$];
  logic [63:0] exp_pc;
  bit          out_pend;
  bit          out_stale;
  logic [63:0] out_addr;
  bit          prev_stall;
  logic [63:0] prev_addr;

  // Memory model
  bit          mem_pend;
  logic [63:0] mem_addr;
  int          mem_delay;
  int          mem_lat = 1;

  typedef struct {
    logic        cpu_ready;
    logic        mem_rdy;
    logic        exp_req_valid;
    logic [63:0] exp_req_addr;
    logic        exp_inst_valid;
    logic [63:0] exp_inst_pc;
  } vec_t;
  vec_t vecs[10];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick_row(input int row);
    bit c_acc, c_resp, c_redir, c_pop, c_reset, c_reqv, c_rdy;
    logic [63:0] c_addr, c_rpc;
    @(negedge clk);
    if (row >= 0) begin
      chk($sformatf("vec%0d_req_valid", row), 64'(imem_req_valid), 64'(vecs[row].exp_req_valid));
      if (vecs[row].exp_req_valid)
        chk($sformatf("vec%0d_req_addr", row), imem_req_addr, vecs[row].exp_req_addr);
      chk($sformatf("vec%0d_inst_valid", row), 64'(inst_valid), 64'(vecs[row].exp_inst_valid));
      if (vecs[row].exp_inst_valid) begin
        chk($sformatf("vec%0d_inst_pc", row), inst_pc, vecs[row].exp_inst_pc);
        chk($sformatf("vec%0d_inst", row), 64'(inst), 64'(mem_word(vecs[row].exp_inst_pc)));
      end
    end
    if (reset) begin
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_inst", 64'(inst), 64'd0);
      chk("rst_inst_pc", inst_pc, 64'd0);
    end else begin
      chk("m_inst_valid", 64'(inst_valid), 64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        chk("m_inst_pc", inst_pc, model_q[0].pc);
        chk("m_inst", 64'(inst), 64'(model_q[0].ins));
      end
      if (imem_req_valid) chk("m_req_addr", imem_req_addr, exp_pc);
      if (prev_stall) begin
        chk("m_hold_valid", 64'(imem_req_valid), 64'd1);
        chk("m_hold_addr", imem_req_addr, prev_addr);
      end
    end
    c_reset = reset;
    c_reqv  = imem_req_valid;
    c_rdy   = imem_req_ready;
    c_acc   = imem_req_valid && imem_req_ready;
    c_addr  = imem_req_addr;
    c_resp  = imem_resp_valid;
    c_redir = redirect_valid;
    c_rpc   = redirect_pc;
    c_pop   = inst_ready && (model_q.size() != 0);
    @(posedge clk);
    #1;
    if (c_reset) begin
      model_q.delete();
      exp_pc     = 64'd0;
      out_pend   = 1'b0;
      out_stale  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (c_acc) chk("m_single_outstanding", 64'(out_pend), 64'd0);
      if (c_pop) void'(model_q.pop_front());
      if (c_resp && out_pend) begin
        if (!out_stale && !c_redir) model_q.push_back('{out_addr, mem_word(out_addr)});
        out_pend = 1'b0;
      end
      if (c_acc) begin
        out_pend  = 1'b1;
        out_stale = c_redir;
        out_addr  = exp_pc;
        exp_pc    = exp_pc + 64'd4;
      end
      if (c_redir) begin
        model_q.delete();
        exp_pc = c_rpc;
        if (out_pend) out_stale = 1'b1;
      end
      if (model_q.size() > DEPTH) chk("m_overflow", 64'(model_q.size()), 64'(DEPTH));
      prev_stall = c_reqv && !c_rdy && !c_redir;
      prev_addr  = c_addr;
    end
    if (c_resp) imem_resp_valid = 1'b0;
    if (c_acc) begin
      mem_pend  = 1'b1;
      mem_addr  = c_addr;
      mem_delay = mem_lat;
    end
    if (mem_pend) begin
      mem_delay--;
      if (mem_delay <= 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
        mem_pend        = 1'b0;
      end
    end
  endtask

  task automatic tick();
    tick_row(-1);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    mem_pend        = 1'b0;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_inst(input string name, input logic [63:0] pc);
    for (int k = 0; k < 40; k++) begin
      if (inst_valid) break;
      tick();
    end
    chk({name, "_seen"}, 64'(inst_valid), 64'd1);
    if (inst_valid) begin
      chk({name, "_pc"}, inst_pc, pc);
      chk({name, "_inst"}, 64'(inst), 64'(mem_word(pc)));
    end
  endtask

  task automatic wait_req(input string name);
    for (int k = 0; k < 20; k++) begin
      if (imem_req_valid) break;
      tick();
    end
    chk({name, "_req_seen"}, 64'(imem_req_valid), 64'd1);
  endtask

  task automatic drain4(input string name, input logic [63:0] base);
    int got;
    got = 0;
    inst_ready = 1'b1;
    for (int k = 0; k < 40 && got < 4; k++) begin
      if (inst_valid) begin
        chk($sformatf("%s_pc%0d", name, got), inst_pc, base + 64'(got * 4));
        got++;
      end
      tick();
    end
    chk({name, "_count"}, 64'(got), 64'd4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    exp_pc          = '0;
    out_pend        = 1'b0;
    out_stale       = 1'b0;
    out_addr        = '0;
    prev_stall      = 1'b0;
    prev_addr       = '0;
    mem_pend        = 1'b0;
    mem_addr        = '0;
    mem_delay       = 0;

    // Streaming with ready memory, 1-cycle response, CPU always ready.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 64'd0,  1'b0, 64'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 64'd0,  1'b0, 64'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 64'd0,  1'b0, 64'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 64'd4,  1'b1, 64'd0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 64'd0,  1'b0, 64'd0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 64'd8,  1'b1, 64'd4};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 64'd0,  1'b0, 64'd0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 64'd12, 1'b1, 64'd8};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 64'd0,  1'b0, 64'd0};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 64'd16, 1'b1, 64'd12};

    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 10; i++) begin
      inst_ready     = vecs[i].cpu_ready;
      imem_req_ready = vecs[i].mem_rdy;
      tick_row(i);
    end

    // Stalled CPU: queue fills, fetching stops, nothing is lost.
    do_reset();
    inst_ready = 1'b0;
    repeat (16) tick();
    for (int k = 0; k < 3; k++) begin
      chk("sat_req_valid", 64'(imem_req_valid), 64'd0);
      chk("sat_inst_pc", inst_pc, 64'd0);
      tick();
    end
    drain4("sat_drain", 64'd0);

    // Redirect while waiting, response arriving later (discarded).
    do_reset();
    inst_ready = 1'b1;
    mem_lat    = 3;
    wait_req("rw3");
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    tick();
    redirect_valid = 1'b0;
    wait_inst("rw3_first", 64'h100);

    // Redirect in the same cycle as the response.
    do_reset();
    mem_lat = 1;
    wait_req("rw1");
    tick();
    chk("rw1_resp_pending", 64'(imem_resp_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    tick();
    redirect_valid = 1'b0;
    wait_inst("rw1_first", 64'h200);

    // Near-full queue: pop and response on the same edge.
    do_reset();
    inst_ready = 1'b0;
    mem_lat    = 1;
    repeat (16) tick();
    mem_lat    = 3;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (imem_resp_valid) break;
      tick();
    end
    chk("pp_resp_seen", 64'(imem_resp_valid), 64'd1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    repeat (12) tick();
    chk("pp_full_req_valid", 64'(imem_req_valid), 64'd0);
    drain4("pp_drain", 64'd8);

    // Memory stall holds the request; redirect retargets it.
    do_reset();
    imem_req_ready = 1'b0;
    inst_ready     = 1'b1;
    mem_lat        = 1;
    wait_req("st");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("st_hold_valid", 64'(imem_req_valid), 64'd1);
      chk("st_hold_addr", imem_req_addr, 64'd0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h300;
    tick();
    redirect_valid = 1'b0;
    chk("st_redir_valid", 64'(imem_req_valid), 64'd1);
    chk("st_redir_addr", imem_req_addr, 64'h300);
    imem_req_ready = 1'b1;
    wait_inst("st_first", 64'h300);

    // Reset while waiting for a response.
    do_reset();
    inst_ready = 1'b0;
    mem_lat    = 1;
    repeat (4) tick();
    chk("rs_pre_inst_valid", 64'(inst_valid), 64'd1);
    chk("rs_pre_resp", 64'(imem_resp_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("rs_now_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rs_now_req_addr", imem_req_addr, 64'd0);
    chk("rs_now_inst_valid", 64'(inst_valid), 64'd0);
    chk("rs_now_inst", 64'(inst), 64'd0);
    chk("rs_now_inst_pc", inst_pc, 64'd0);
    tick();
    tick();
    reset           = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    chk("rs_stale_ignored", 64'(inst_valid), 64'd0);
    inst_ready = 1'b1;
    wait_inst("rs_first", 64'd0);

    // Randomised traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      inst_ready     = ($urandom_range(3) != 0);
      imem_req_ready = ($urandom_range(3) != 0);
      mem_lat        = 1 + $urandom_range(2);
      redirect_valid = ($urandom_range(19) == 0);
      if ($urandom_range(3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      else                        redirect_pc = {32'd0, $urandom} & 64'h0000_0000_000F_FFFC;
      if ($urandom_range(499) == 0) do_reset();
      else                          tick();
    end
    redirect_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
